ca_sequencer: RTL and testbench

- Command-driven controller for a 16-cell ring elementary cellular automaton.
- Loads the seed and rule, single-steps, or runs a bounded or unbounded number of generations at a programmable generation period.
- Owns the cell register and the generation counter.
- Sits between a host command interface (valid/ready) and display or logging logic that consumes `cells`.

---
 rtl/ca_pkg.sv | 9 +
 rtl/ca_next_gen.sv | 14 +
 rtl/ca_sequencer.sv | 123 ++++++++++++
 tb/tb_ca_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ca_pkg.sv
// ca_pkg: shared op-codes, FSM state encoding and default ring width for the CA sequencer.
package ca_pkg;
    localparam int CA_WIDTH = 16;
    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_STEP = 2'd1;
    localparam logic [1:0] OP_RUN  = 2'd2;
    localparam logic [1:0] OP_NOP  = 2'd3;
    typedef enum logic {ST_IDLE, ST_RUN} state_t;
endpackage

// File: rtl/ca_next_gen.sv
// ca_next_gen: combinational next generation of a ring elementary cellular automaton.
module ca_next_gen
    import ca_pkg::*;
#(
    parameter int WIDTH = CA_WIDTH
) (
    input  logic [7:0]       rule,
    input  logic [WIDTH-1:0] cells,
    output logic [WIDTH-1:0] next
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign next[i] = rule[{cells[(i+1)%WIDTH], cells[i], cells[(i+WIDTH-1)%WIDTH]}];
    end
endmodule

// File: rtl/ca_sequencer.sv
// ca_sequencer: command-driven controller for a ring elementary cellular automaton.
// Optional CA_FIXED_POINT_HALT_EN halts RUN and raises stable when a generation repeats.
module ca_sequencer
    import ca_pkg::*;
#(
    parameter int WIDTH      = CA_WIDTH,
    parameter int PRESCALE_W = 8,
    parameter int GEN_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [7:0]            cmd_rule,
    input  logic [WIDTH-1:0]      cmd_seed,
    input  logic [GEN_W-1:0]      cmd_gens,
    input  logic [PRESCALE_W-1:0] cmd_period,
    input  logic                  abort,
    output logic [WIDTH-1:0]      cells,
    output logic [GEN_W-1:0]      gen_count,
    output logic                  busy,
    output logic                  done,
    output logic                  stable
);
    state_t                state;
    logic [7:0]            rule_q;
    logic [GEN_W-1:0]      target;
    logic [GEN_W-1:0]      gen_inc;
    logic [PRESCALE_W-1:0] period_q;
    logic [PRESCALE_W-1:0] presc;
    logic [WIDTH-1:0]      nxt;
    logic                  tick;
    logic                  hit;

    ca_next_gen #(.WIDTH(WIDTH)) u_next (
        .rule  (rule_q),
        .cells (cells),
        .next  (nxt)
    );

    assign cmd_ready = state == ST_IDLE;
    assign busy      = state == ST_RUN;
    assign gen_inc   = gen_count + 1'b1;
    assign tick      = presc == period_q;
    // target 0 means unbounded; the match is on the wrapped counter value
    assign hit       = (target != '0) && (gen_inc == target);

`ifdef CA_FIXED_POINT_HALT_EN
    logic fixed;
    assign fixed = nxt == cells;
`else
    assign stable = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cells     <= '0;
            rule_q    <= '0;
            gen_count <= '0;
            target    <= '0;
            period_q  <= '0;
            presc     <= '0;
            done      <= 1'b0;
`ifdef CA_FIXED_POINT_HALT_EN
            stable    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            cells     <= cmd_seed;
                            rule_q    <= cmd_rule;
                            gen_count <= '0;
`ifdef CA_FIXED_POINT_HALT_EN
                            stable    <= 1'b0;
`endif
                        end
                        OP_STEP: begin
                            cells     <= nxt;
                            gen_count <= gen_inc;
                            done      <= 1'b1;
`ifdef CA_FIXED_POINT_HALT_EN
                            if (fixed) stable <= 1'b1;
`endif
                        end
                        OP_RUN: begin
                            target   <= cmd_gens;
                            period_q <= cmd_period;
                            presc    <= '0;
                            state    <= ST_RUN;
                        end
                        default: ;
                    endcase
                end
            end else if (abort) begin
                // abort takes priority over a coinciding tick
                state <= ST_IDLE;
                done  <= 1'b1;
            end else if (tick) begin
                cells     <= nxt;
                gen_count <= gen_inc;
                presc     <= '0;
                if (hit) begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                end
`ifdef CA_FIXED_POINT_HALT_EN
                if (fixed) begin
                    stable <= 1'b1;
                    state  <= ST_IDLE;
                    done   <= 1'b1;
                end
`endif
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ca_sequencer.sv
// tb_ca_sequencer: directed and randomized checks of ca_sequencer against a transaction-level model.
module tb_ca_sequencer;
    localparam int W  = 16;
    localparam int PW = 8;
    localparam int GW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd3;
    logic [7:0]    cmd_rule = '0;
    logic [W-1:0]  cmd_seed = '0;
    logic [GW-1:0] cmd_gens = '0;
    logic [PW-1:0] cmd_period = '0;
    logic          abort = 1'b0;
    logic [W-1:0]  cells;
    logic [GW-1:0] gen_count;
    logic          busy;
    logic          done;
    logic          stable;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0]  m_cells = '0;
    logic [7:0]    m_rule = '0;
    logic [GW-1:0] m_gen = '0;
    logic          m_stable = 1'b0;

    ca_sequencer #(.WIDTH(W), .PRESCALE_W(PW), .GEN_W(GW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rule(cmd_rule), .cmd_seed(cmd_seed), .cmd_gens(cmd_gens),
        .cmd_period(cmd_period), .abort(abort), .cells(cells), .gen_count(gen_count),
        .busy(busy), .done(done), .stable(stable)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_next(input logic [W-1:0] c, input logic [7:0] r);
        logic [W-1:0] n;
        int idx;
        for (int i = 0; i < W; i++) begin
            idx = 4 * int'(c[(i+1)%W]) + 2 * int'(c[i]) + int'(c[(i+W-1)%W]);
            n[i] = r[idx];
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [1:0] op, input logic [7:0] r, input logic [W-1:0] s,
                       input logic [GW-1:0] g, input logic [PW-1:0] p);
        cmd_valid = 1'b1; cmd_op = op; cmd_rule = r; cmd_seed = s; cmd_gens = g; cmd_period = p;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 2'd3; cmd_rule = $urandom; cmd_seed = $urandom;
        cmd_gens = $urandom; cmd_period = $urandom;
    endtask

    task automatic load(input logic [7:0] r, input logic [W-1:0] s);
        cmd(2'd0, r, s, '0, '0);
        m_cells = s; m_rule = r; m_gen = '0; m_stable = 1'b0;
        chk("load_cells", 32'(cells), 32'(m_cells));
        chk("load_gen", 32'(gen_count), 32'(m_gen));
        chk("load_done", 32'(done), 32'd0);
        chk("load_stable", 32'(stable), 32'd0);
    endtask

    task automatic step();
        logic [W-1:0] nc;
        cmd(2'd1, '0, '0, '0, '0);
        nc = ref_next(m_cells, m_rule);
`ifdef CA_FIXED_POINT_HALT_EN
        if (nc == m_cells) m_stable = 1'b1;
`endif
        m_cells = nc; m_gen++;
        chk("step_cells", 32'(cells), 32'(m_cells));
        chk("step_gen", 32'(gen_count), 32'(m_gen));
        chk("step_done", 32'(done), 32'd1);
        chk("step_stable", 32'(stable), 32'(m_stable));
        @(negedge clk);
        chk("step_done_clr", 32'(done), 32'd0);
    endtask

    // One RUN transaction; ab_k>0 raises abort so that the k-th edge after accept sees it.
    task automatic run(input logic [GW-1:0] g, input logic [PW-1:0] p, input int ab_k);
        logic [W-1:0] nc;
        bit ended = 0;
        cmd(2'd2, '0, '0, g, p);
        chk("run_ready", 32'(cmd_ready), 32'd0);
        chk("run_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 4000 && !ended; k++) begin
            abort = (ab_k != 0 && k == ab_k);
            @(negedge clk);
            if (ab_k != 0 && k == ab_k) ended = 1;
            else if (k % (int'(p) + 1) == 0) begin
                nc = ref_next(m_cells, m_rule);
`ifdef CA_FIXED_POINT_HALT_EN
                if (nc == m_cells) begin m_stable = 1'b1; ended = 1; end
`endif
                m_cells = nc; m_gen++;
                if (g != '0 && m_gen == g) ended = 1;
            end
            chk("run_cells", 32'(cells), 32'(m_cells));
            chk("run_gen", 32'(gen_count), 32'(m_gen));
            chk("run_done", 32'(done), 32'(ended));
            chk("run_busy", 32'(busy), 32'(!ended));
            chk("run_ready", 32'(cmd_ready), 32'(ended));
        end
        abort = 1'b0;
        chk("run_terminated", 32'(ended), 32'd1);
        chk("run_stable", 32'(stable), 32'(m_stable));
        @(negedge clk);
        chk("run_done_clr", 32'(done), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_cells", 32'(cells), 32'd0);
        chk("rst_gen", 32'(gen_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stable", 32'(stable), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);

        load(8'd30, 16'h0001);
        step();
        chk("rule30_value", 32'(cells), 32'h8003);

        load(8'd170, 16'h0001);
        run(16'd16, 8'd0, 0);
        chk("rot16_value", 32'(cells), 32'h0001);

        load(8'd170, 16'h0001);
        run(16'd2, 8'd3, 0);
        chk("period3_value", 32'(cells), 32'h0004);

        load(8'd170, 16'h0001);
        run(16'd0, 8'd0, 6);
        chk("abort_gen", 32'(gen_count), 32'd5);

        abort = 1'b1;
        step();
        abort = 1'b0;

        load(8'd204, 16'hA5A5);
        run(16'd0, 8'd1, 12);
        step();
        load(8'd204, 16'hA5A5);

        for (int r = 0; r < 10; r++) begin
            load(8'($urandom), 16'($urandom));
            repeat ($urandom_range(0, 2)) step();
            run(m_gen + 16'($urandom_range(1, 12)), 8'($urandom_range(0, 3)),
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 30)) : 0);
        end

        load(8'd170, 16'h0001);
        cmd(2'd2, '0, '0, '0, '0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_cells", 32'(cells), 32'd0);
        chk("mid_rst_gen", 32'(gen_count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_idle_done", 32'(done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
